wb_line_responder: RTL and testbench

- Wishbone slave that answers the pipelined core's line-granular instruction-fetch and data-memory master ports.
- Holds a DEPTH-line array of 128-bit lines and serves single-line reads and byte-masked writes.
- Applies a fixed, configurable access latency, so the core's fetch and memory stages can be exercised against realistic memory timing.
- One instance sits behind each master port: ifetch and memory.

---
 rtl/wb_line_responder_if.sv | 43 ++++
 rtl/wb_line_responder.sv | 212 +++++++++++++++++++++
 tb/tb_wb_line_responder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_line_responder_if.sv
// wb_line_responder_if
//
// Purpose:
//   Bundles the Wishbone signals between a line-granular master port
//   (instruction fetch or data memory) and a wb_line_responder.
//
// Signals:
//   CYC    master -> slave  cycle valid
//   STB    master -> slave  strobe
//   WE     master -> slave  1 = write, 0 = read
//   ADR    master -> slave  line address (byte address bits [15:4])
//   SEL    master -> slave  byte-lane enables, bit i covers DAT_M[8i+7:8i]
//   DAT_M  master -> slave  write data
//   DAT_S  slave -> master  read data
//   ACK    slave -> master  normal termination, one-cycle pulse
//   ERR    slave -> master  error termination, one-cycle pulse
//
// Modports:
//   master  drives the request side.
//   slave   drives the response side.
interface wb_line_responder_if #(
    parameter int ADR_W = 12
) ();
    logic             CYC;
    logic             STB;
    logic             WE;
    logic [ADR_W-1:0] ADR;
    logic [15:0]      SEL;
    logic [127:0]     DAT_M;
    logic [127:0]     DAT_S;
    logic             ACK;
    logic             ERR;

    modport master (
        output CYC, STB, WE, ADR, SEL, DAT_M,
        input  DAT_S, ACK, ERR
    );

    modport slave (
        input  CYC, STB, WE, ADR, SEL, DAT_M,
        output DAT_S, ACK, ERR
    );
endinterface

// File: rtl/wb_line_responder.sv
// wb_line_responder
//
// Purpose:
//   Wishbone slave holding DEPTH lines of 128 bits. It serves single-line
//   reads and byte-masked writes with a fixed access latency, so the core's
//   fetch and memory stages see realistic memory timing. Each request
//   produces exactly one ACK or ERR pulse, followed by one mandatory dead
//   cycle before the next request can be captured.
//
// Parameters:
//   LATENCY  clock edges from request capture to ACK/ERR (>= 1)
//   DEPTH    number of implemented lines; line addresses >= DEPTH get ERR
//   ADR_W    line address width
//
// Ports:
//   clk       system clock, all state changes on the rising edge
//   rst       synchronous active-high reset
//   bus       Wishbone slave modport (CYC/STB/WE/ADR/SEL/DAT_M in,
//             DAT_S/ACK/ERR out)
//   rd_count  (only with WB_LINE_RESPONDER_STATS_EN) acknowledged reads
//   wr_count  (only with WB_LINE_RESPONDER_STATS_EN) acknowledged writes
//
// Optional feature:
//   Define WB_LINE_RESPONDER_STATS_EN to add the rd_count/wr_count
//   statistics outputs. Without it the ports and counters are absent.
module wb_line_responder #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 256,
    parameter int ADR_W   = 12
) (
    input  logic clk,
    input  logic rst,
    wb_line_responder_if.slave bus
`ifdef WB_LINE_RESPONDER_STATS_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
`endif
);

    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One extra bit so the range check still works when DEPTH == 2**ADR_W
    // (in that case no address can reach it and ERR never asserts).
    localparam logic [ADR_W:0] DEPTH_EXT = (ADR_W + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [127:0]     mem [DEPTH];

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             we_q;
    logic [ADR_W-1:0] adr_q;
    logic [15:0]      sel_q;
    logic [127:0]     dat_q;

    logic             ack_q;
    logic             err_q;
    logic [127:0]     dat_s_q;

    logic             req;
    logic             complete;
    logic             cmp_we;
    logic [ADR_W-1:0] cmp_adr;
    logic [15:0]      cmp_sel;
    logic [127:0]     cmp_dat;
    logic             cmp_oor;
    logic [IDX_W-1:0] cmp_idx;
    logic             do_write;

    assign req = bus.CYC & bus.STB;

    // The completion edge is the one that enters RESP. With LATENCY == 1
    // that is the capture edge itself, so the request comes straight from
    // the bus; otherwise it comes from the latched copy, which makes the
    // transfer immune to master changes after capture.
    assign complete = ((state_q == ST_IDLE) && req && (LATENCY == 1)) ||
                      ((state_q == ST_BUSY) && bus.CYC && (cnt_q == CNT_W'(1)));

    assign cmp_we  = (state_q == ST_IDLE) ? bus.WE    : we_q;
    assign cmp_adr = (state_q == ST_IDLE) ? bus.ADR   : adr_q;
    assign cmp_sel = (state_q == ST_IDLE) ? bus.SEL   : sel_q;
    assign cmp_dat = (state_q == ST_IDLE) ? bus.DAT_M : dat_q;

    assign cmp_oor  = ({1'b0, cmp_adr} >= DEPTH_EXT);
    assign cmp_idx  = cmp_adr[IDX_W-1:0];
    assign do_write = complete & cmp_we & ~cmp_oor;

    // Next-state logic. Dropping CYC while busy abandons the transfer
    // silently; RESP always falls back to IDLE, giving the dead cycle
    // between terminations even when the master holds STB high.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            ST_BUSY: begin
                if (!bus.CYC) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and latched request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            sel_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if ((state_q == ST_IDLE) && req) begin
                we_q  <= bus.WE;
                adr_q <= bus.ADR;
                sel_q <= bus.SEL;
                dat_q <= bus.DAT_M;
            end
        end
    end

    // Response registers. DAT_S only changes on a completion edge (or
    // reset) so the master can sample it any time after the ACK.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_s_q <= '0;
        end else begin
            ack_q <= complete & ~cmp_oor;
            err_q <= complete &  cmp_oor;
            if (complete) begin
                if (cmp_oor || cmp_we) begin
                    dat_s_q <= '0;
                end else begin
                    dat_s_q <= mem[cmp_idx];
                end
            end
        end
    end

    // Line storage is deliberately not reset. Only enabled byte lanes of
    // the addressed line are written; reset suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && do_write) begin
            for (int i = 0; i < 16; i++) begin
                if (cmp_sel[i]) begin
                    mem[cmp_idx][8*i +: 8] <= cmp_dat[8*i +: 8];
                end
            end
        end
    end

    assign bus.ACK   = ack_q;
    assign bus.ERR   = err_q;
    assign bus.DAT_S = dat_s_q;

`ifdef WB_LINE_RESPONDER_STATS_EN
    logic [31:0] rd_count_q;
    logic [31:0] wr_count_q;

    // Counted at the end of each ACK cycle; ERR and aborted transfers
    // never raise ACK, so they are excluded automatically.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else if (ack_q) begin
            if (we_q) begin
                wr_count_q <= wr_count_q + 32'd1;
            end else begin
                rd_count_q <= rd_count_q + 32'd1;
            end
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_wb_line_responder.sv
// tb_wb_line_responder
//
// Directed bench for wb_line_responder. Two instances are used: one with
// LATENCY = 2 and one with LATENCY = 4 (for the abort scenario). Both use
// DEPTH = 256 and ADR_W = 12.
module tb_wb_line_responder;

    logic clk;
    logic rst;

    int checks;
    int errors;

    wb_line_responder_if #(.ADR_W(12)) b2 ();
    wb_line_responder_if #(.ADR_W(12)) b4 ();

`ifdef WB_LINE_RESPONDER_STATS_EN
    logic [31:0] rdCount2, wrCount2, rdCount4, wrCount4;
`endif

    wb_line_responder #(.LATENCY(2), .DEPTH(256), .ADR_W(12)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .bus      (b2)
`ifdef WB_LINE_RESPONDER_STATS_EN
        ,
        .rd_count (rdCount2),
        .wr_count (wrCount2)
`endif
    );

    wb_line_responder #(.LATENCY(4), .DEPTH(256), .ADR_W(12)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .bus      (b4)
`ifdef WB_LINE_RESPONDER_STATS_EN
        ,
        .rd_count (rdCount4),
        .wr_count (wrCount4)
`endif
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
        end
    endtask

    // Drive one bus (onL4 selects the LATENCY = 4 instance).
    task automatic applyStimulus(input bit onL4, input logic cyc, input logic stb,
                                 input logic we, input logic [11:0] adr,
                                 input logic [15:0] sel, input logic [127:0] dat);
        if (onL4) begin
            b4.CYC = cyc; b4.STB = stb; b4.WE = we;
            b4.ADR = adr; b4.SEL = sel; b4.DAT_M = dat;
        end else begin
            b2.CYC = cyc; b2.STB = stb; b2.WE = we;
            b2.ADR = adr; b2.SEL = sel; b2.DAT_M = dat;
        end
    endtask

    task automatic getResp(input bit onL4, output logic ack, output logic err,
                           output logic [127:0] dat);
        if (onL4) begin
            ack = b4.ACK; err = b4.ERR; dat = b4.DAT_S;
        end else begin
            ack = b2.ACK; err = b2.ERR; dat = b2.DAT_S;
        end
    endtask

    // One complete transfer: checks silence for LATENCY-1 cycles after
    // capture, the termination in the following cycle, and that the
    // termination is a single-cycle pulse.
    task automatic xfer(input bit onL4, input int lat, input string tag,
                        input logic we, input logic [11:0] adr,
                        input logic [15:0] sel, input logic [127:0] dat,
                        input logic expErr, input logic [127:0] expDat);
        logic          ack, err;
        logic [127:0]  rdat;
        @(negedge clk);
        applyStimulus(onL4, 1'b1, 1'b1, we, adr, sel, dat);
        @(posedge clk);
        for (int k = 0; k < lat - 1; k++) begin
            @(negedge clk);
            getResp(onL4, ack, err, rdat);
            checkOutput({tag, "_early_ackerr"}, {126'd0, ack, err}, 128'd0);
            @(posedge clk);
        end
        @(negedge clk);
        getResp(onL4, ack, err, rdat);
        checkOutput({tag, "_ack"}, {127'd0, ack}, {127'd0, ~expErr});
        checkOutput({tag, "_err"}, {127'd0, err}, {127'd0, expErr});
        checkOutput({tag, "_dat"}, rdat, expDat);
        applyStimulus(onL4, 1'b0, 1'b0, 1'b0, 12'd0, 16'd0, 128'd0);
        @(negedge clk);
        getResp(onL4, ack, err, rdat);
        checkOutput({tag, "_pulse_end"}, {126'd0, ack, err}, 128'd0);
    endtask

    localparam logic [127:0] PAT_A   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] PAT_Z   = 128'hA5A5A5A5_0F0F0F0F_12345678_9ABCDEF0;
    localparam logic [127:0] PAT_P   = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    localparam logic [127:0] PAT_Q   = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] ALL_FF  = {128{1'b1}};
    localparam logic [127:0] PART_D  = 128'h00000000_00000000_00001234_00000000;
    localparam logic [127:0] PART_E  = 128'hFFFFFFFF_FFFFFFFF_FFFF1234_FFFFFFFF;

    initial begin
        int  ackCount;
        int  badSpacing;
        int  sawResp;
        logic prevAck;

        checks = 0;
        errors = 0;
        rst    = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 16'd0, 128'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 16'd0, 128'd0);
        repeat (3) @(posedge clk);

        // Reset state
        @(negedge clk);
        checkOutput("reset_ack2",  {127'd0, b2.ACK}, 128'd0);
        checkOutput("reset_err2",  {127'd0, b2.ERR}, 128'd0);
        checkOutput("reset_dat2",  b2.DAT_S, 128'd0);
        checkOutput("reset_ack4",  {127'd0, b4.ACK}, 128'd0);
`ifdef WB_LINE_RESPONDER_STATS_EN
        checkOutput("reset_rdcnt", {96'd0, rdCount2}, 128'd0);
        checkOutput("reset_wrcnt", {96'd0, wrCount2}, 128'd0);
`endif
        rst = 1'b0;

        // Full-line write and readback
        xfer(1'b0, 2, "full_wr", 1'b1, 12'h005, 16'hFFFF, PAT_A, 1'b0, 128'd0);
        xfer(1'b0, 2, "full_rd", 1'b0, 12'h005, 16'h0000, 128'd0, 1'b0, PAT_A);

        // Partial write: only bytes 4..5 change
        xfer(1'b0, 2, "pre_ff", 1'b1, 12'h010, 16'hFFFF, ALL_FF, 1'b0, 128'd0);
        xfer(1'b0, 2, "part_wr", 1'b1, 12'h010, 16'h0030, PART_D, 1'b0, 128'd0);
        xfer(1'b0, 2, "part_rd", 1'b0, 12'h010, 16'h0000, 128'd0, 1'b0, PART_E);

        // SEL = 0 write: acknowledged, line unchanged
        xfer(1'b0, 2, "sel0_wr", 1'b1, 12'h010, 16'h0000, 128'd0, 1'b0, 128'd0);
        xfer(1'b0, 2, "sel0_rd", 1'b0, 12'h010, 16'h0000, 128'd0, 1'b0, PART_E);

        // Out of range read/write, then a normal read of line 0
        xfer(1'b0, 2, "z_wr", 1'b1, 12'h000, 16'hFFFF, PAT_Z, 1'b0, 128'd0);
        xfer(1'b0, 2, "oor_rd", 1'b0, 12'h100, 16'hFFFF, 128'd0, 1'b1, 128'd0);
        xfer(1'b0, 2, "oor_wr", 1'b1, 12'hFFF, 16'hFFFF, PAT_P, 1'b1, 128'd0);
        xfer(1'b0, 2, "z_rd", 1'b0, 12'h000, 16'h0000, 128'd0, 1'b0, PAT_Z);

        // Continuous strobe: 30 cycles of CYC = STB = 1 give 10 ACKs,
        // visible one cycle after edges 1, 4, 7, ... 28 of the window.
        ackCount   = 0;
        badSpacing = 0;
        prevAck    = 1'b0;
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'h005, 16'hFFFF, 128'd0);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (b2.ACK === 1'b1) ackCount++;
            if ((b2.ACK === 1'b1) != ((c % 3) == 1)) badSpacing++;
            if ((b2.ACK === 1'b1) && prevAck) badSpacing++;
            prevAck = b2.ACK;
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 16'd0, 128'd0);
        checkOutput("stream_acks", 128'(ackCount), 128'd10);
        checkOutput("stream_spacing", 128'(badSpacing), 128'd0);
        checkOutput("stream_dat", b2.DAT_S, PAT_A);
        @(negedge clk);
        @(negedge clk);
`ifdef WB_LINE_RESPONDER_STATS_EN
        checkOutput("stats_rd", {96'd0, rdCount2}, 128'd14);
        checkOutput("stats_wr", {96'd0, wrCount2}, 128'd5);
`endif

        // Abort on the LATENCY = 4 instance
        xfer(1'b1, 4, "ab_pre", 1'b1, 12'h020, 16'hFFFF, PAT_P, 1'b0, 128'd0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 12'h020, 16'hFFFF, PAT_Q);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 16'd0, 128'd0);
        sawResp = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if ((b4.ACK !== 1'b0) || (b4.ERR !== 1'b0)) sawResp++;
        end
        checkOutput("abort_no_resp", 128'(sawResp), 128'd0);
        xfer(1'b1, 4, "ab_rd", 1'b0, 12'h020, 16'h0000, 128'd0, 1'b0, PAT_P);

        // Reset during the RESP cycle of a read
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'h005, 16'h0000, 128'd0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_resp_ack", {127'd0, b2.ACK}, 128'd1);
        checkOutput("rst_resp_dat", b2.DAT_S, PAT_A);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 16'd0, 128'd0);
        checkOutput("rst_mid_ack", {127'd0, b2.ACK}, 128'd0);
        checkOutput("rst_mid_err", {127'd0, b2.ERR}, 128'd0);
        checkOutput("rst_mid_dat", b2.DAT_S, 128'd0);
`ifdef WB_LINE_RESPONDER_STATS_EN
        checkOutput("rst_mid_rdcnt", {96'd0, rdCount2}, 128'd0);
`endif
        @(negedge clk);
        checkOutput("rst_idle_ack", {127'd0, b2.ACK}, 128'd0);
        // Array survives reset and the responder restarts from IDLE
        xfer(1'b0, 2, "post_rst_rd", 1'b0, 12'h005, 16'h0000, 128'd0, 1'b0, PAT_A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
